// File: rtl/norm2_div_pkg.sv
// Shared types and default widths for the norm2 sequential unsigned divider.
package norm2_div_pkg;

   localparam int DIVIDEND_W_DEF = 31;
   localparam int DIVISOR_W_DEF  = 6;
   localparam int QUOTIENT_W_DEF = 25;
   localparam int CNT_W          = $clog2(DIVIDEND_W_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/norm2_udiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, restore on borrow.
module norm2_udiv_step #(
   parameter int DIVISOR_W = 6
) (
   input  logic [DIVISOR_W:0]   rem_i,
   input  logic                 bit_i,
   input  logic [DIVISOR_W-1:0] divisor_i,
   output logic [DIVISOR_W:0]   rem_o,
   output logic                 qbit_o
);

   localparam int SW = DIVISOR_W + 2;
   localparam int TW = DIVISOR_W + 3;

   logic [SW-1:0] shifted;
   logic [TW-1:0] trial;

   always_comb begin
      shifted = {rem_i, bit_i};
      // One extra top bit so the borrow of the trial subtract is visible.
      trial   = {1'b0, shifted} - TW'(divisor_i);
      qbit_o  = ~trial[TW-1];
      rem_o   = qbit_o ? (DIVISOR_W+1)'(trial) : (DIVISOR_W+1)'(shifted);
   end

endmodule

// File: rtl/norm2_udiv_31ns_6ns_25_seq.sv
// Sequential restoring divider: 31-bit dividend / 6-bit divisor -> 25-bit quotient, 6-bit remainder.
module norm2_udiv_31ns_6ns_25_seq
   import norm2_div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF,
   parameter int QUOTIENT_W = QUOTIENT_W_DEF
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOTIENT_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  overflow
);

   localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

   state_e                state_q;
   logic [CW-1:0]         cnt_q;
   logic [DIVISOR_W:0]    prem_q;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB.
   logic [DIVIDEND_W-1:0] quo_q;
   logic [DIVISOR_W-1:0]  dsr_q;
   logic [QUOTIENT_W-1:0] quot_q;
   logic [DIVISOR_W-1:0]  rem_q;
   logic                  dbz_q;
   logic                  ovf_q;
   logic                  vld_q;

   logic [DIVISOR_W:0]    rem_d;
   logic                  qbit_d;
   logic [DIVIDEND_W-1:0] quo_d;

   norm2_udiv_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .rem_i     (prem_q),
      .bit_i     (quo_q[DIVIDEND_W-1]),
      .divisor_i (dsr_q),
      .rem_o     (rem_d),
      .qbit_o    (qbit_d)
   );

   assign quo_d = {quo_q[DIVIDEND_W-2:0], qbit_d};

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         quo_q   <= '0;
         dsr_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (divisor == '0) begin
                     state_q <= DONE;
                     quot_q  <= '1;
                     rem_q   <= dividend[DIVISOR_W-1:0];
                     dbz_q   <= 1'b1;
                     ovf_q   <= 1'b0;
                     vld_q   <= 1'b1;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= CW'(DIVIDEND_W - 1);
                     prem_q  <= '0;
                     quo_q   <= dividend;
                     dsr_q   <= divisor;
                  end
               end
            end
            BUSY: begin
               prem_q <= rem_d;
               quo_q  <= quo_d;
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  quot_q  <= quo_d[QUOTIENT_W-1:0];
                  rem_q   <= rem_d[DIVISOR_W-1:0];
                  dbz_q   <= 1'b0;
                  // Shift form stays legal when QUOTIENT_W == DIVIDEND_W.
                  ovf_q   <= (quo_d >> QUOTIENT_W) != '0;
                  vld_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
                  vld_q   <= 1'b0;
                  dbz_q   <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = vld_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_norm2_udiv_31ns_6ns_25_seq.sv
// Directed bench for the norm2 divider; latency is counted in clock edges after the accept edge.
module tb_norm2_udiv_31ns_6ns_25_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [30:0] dividend = '0;
   logic [5:0]  divisor = '0;
   logic        in_ready, out_valid, div_by_zero, overflow;
   logic [24:0] quotient;
   logic [5:0]  remainder;

   int total = 0;
   int bad = 0;

   logic [24:0] m_q;
   logic [5:0]  m_r;
   logic        m_dbz, m_ovf;
   logic        m_act = 1'b0;

   norm2_udiv_31ns_6ns_25_seq dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Plain-arithmetic reference for the most recently accepted operand pair.
   task automatic set_model(input logic [30:0] a, input logic [5:0] b);
      longint la, lb, qa, ra;
      la = longint'(a);
      lb = longint'(b);
      if (lb == 0) begin
         m_q   = '1;
         m_r   = a[5:0];
         m_dbz = 1'b1;
         m_ovf = 1'b0;
      end else begin
         qa    = la / lb;
         ra    = la % lb;
         m_q   = qa[24:0];
         m_r   = ra[5:0];
         m_dbz = 1'b0;
         m_ovf = (qa > 64'd33554431);
      end
      m_act = 1'b1;
   endtask

   always @(negedge ap_clk) begin
      if (ap_rst_n && out_valid) begin
         if (m_act) begin
            chk("model_quotient", quotient, m_q);
            chk("model_remainder", remainder, m_r);
            chk("model_dbz", div_by_zero, m_dbz);
            chk("model_ovf", overflow, m_ovf);
         end
         chk("done_in_ready", in_ready, 0);
      end
   end

   task automatic wait_result(input string nm, input int elat);
      int lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge ap_clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, lat, elat);
   endtask

   task automatic release_result(input string nm);
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      chk({nm, "_idle"}, {out_valid, in_ready, div_by_zero, overflow}, 4'b0100);
   endtask

   // Called #1 after a rising edge with the DUT idle.
   task automatic do_op(input logic [30:0] a, input logic [5:0] b, input logic [24:0] eq,
                        input logic [5:0] er, input logic edbz, input logic eovf,
                        input int elat, input string nm);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      chk({nm, "_in_ready"}, in_ready, 1);
      @(posedge ap_clk);
      set_model(a, b);
      #1 in_valid = 1'b0;
      wait_result(nm, elat);
      chk({nm, "_quotient"}, quotient, eq);
      chk({nm, "_remainder"}, remainder, er);
      chk({nm, "_dbz"}, div_by_zero, edbz);
      chk({nm, "_ovf"}, overflow, eovf);
      release_result(nm);
   endtask

   initial begin
      #2;
      chk("rst_state", {in_ready, out_valid, div_by_zero, overflow}, 4'b1000);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      #11 ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;

      do_op(31'd37000000, 6'd37, 25'd1000000, 6'd0, 1'b0, 1'b0, 31, "exact");
      do_op(31'd100, 6'd7, 25'd14, 6'd2, 1'b0, 1'b0, 31, "small");
      do_op(31'd5, 6'd63, 25'd0, 6'd5, 1'b0, 1'b0, 31, "lt_div");
      do_op(31'h12345AB, 6'd0, 25'h1FFFFFF, 6'h2B, 1'b1, 1'b0, 0, "dbz");
      do_op(31'h7FFFFFFF, 6'd1, 25'h1FFFFFF, 6'd0, 1'b0, 1'b1, 31, "ovf_div1");
      // 2^31-1 / 63 = 34087042 needs 26 bits: truncated to 0x0082082 with overflow.
      do_op(31'h7FFFFFFF, 6'd63, 25'h0082082, 6'd1, 1'b0, 1'b1, 31, "ovf_div63");

      // Backpressure, with a second pair held on in_valid throughout.
      dividend = 31'd1000; divisor = 6'd9; in_valid = 1'b1;
      @(posedge ap_clk);
      set_model(31'd1000, 6'd9);
      #1 dividend = 31'd200; divisor = 6'd3;
      wait_result("bp1", 31);
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_q", quotient, 111);
         chk("bp_hold_r", remainder, 1);
         chk("bp_hold_v", {out_valid, in_ready}, 2'b10);
         @(posedge ap_clk); #1;
      end
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      chk("bp_handshake", {out_valid, in_ready}, 2'b01);
      @(posedge ap_clk);
      set_model(31'd200, 6'd3);
      #1 in_valid = 1'b0;
      chk("bp2_accepted", in_ready, 0);
      wait_result("bp2", 31);
      chk("bp2_quotient", quotient, 66);
      chk("bp2_remainder", remainder, 2);
      release_result("bp2");

      // Asynchronous reset in the middle of BUSY.
      dividend = 31'd37000000; divisor = 6'd37; in_valid = 1'b1;
      @(posedge ap_clk);
      set_model(31'd37000000, 6'd37);
      #1 in_valid = 1'b0;
      repeat (11) @(posedge ap_clk);
      #4 ap_rst_n = 1'b0;
      m_act = 1'b0;
      #1;
      chk("abort_flags", {in_ready, out_valid, div_by_zero, overflow}, 4'b1000);
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      #7 ap_rst_n = 1'b1;
      begin
         int stale = 0;
         for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk); #1;
            if (out_valid || !in_ready) stale++;
         end
         chk("abort_no_stale", stale, 0);
      end
      do_op(31'd100, 6'd7, 25'd14, 6'd2, 1'b0, 1'b0, 31, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1);
   end

endmodule
